ifetch_data_stage: RTL and testbench
====================================

# ifetch_data_stage

Second instruction-fetch pipeline stage, directly downstream of `ifetch_tag_stage`. It takes the PC and warp index latched by the tag stage, compares the way tags read from the L1 icache, and on a hit selects the 32-bit instruction word and registers it toward decode. On a miss it reports a one-cycle miss or near-miss pulse back to the tag stage, which suspends or retries that warp, and queues a line-fill request to the L2 interface.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width.
- `NUM_WARP_PER_CORE`, 4, warps per core; `NUM_WARP_PER_CORE_LOG` = clog2.
- `L1_CACHE_NUM_WAYS`, 4, icache associativity.
- `L1_CACHE_NUM_SETS`, 64, icache sets; `L1_CACHE_NUM_SETS_LOG` = 6.
- `CACHE_LINE_BYTES`, 64, line size; offset width is 6, so the tag is `ADDR_WIDTH`-12 = 20 bits.
- `MISS_FIFO_DEPTH`, 2, depth of the pending L2 request FIFO (power of two).

Ports (clock and reset: `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ift_to_ifd_valid`  in  1  tag-stage output valid.
- `ift_to_ifd_bus`  in  `ADDR_WIDTH`+`NUM_WARP_PER_CORE_LOG`  {pc, warp_idx}.
- `ifd_allowin`  out  1  stage can accept this cycle.
- `icache_tag_valid`  in  WAYS  per-way valid bits for the looked-up set.
- `icache_tag`  in  WAYS×20  per-way tags.
- `icache_data`  in  WAYS×512  per-way line data.
- `l2i_fill_en`  in  1  L2 is writing a line this cycle.
- `l2i_fill_set_idx`  in  6  set of the line being filled.
- `l2i_fill_tag`  in  20  tag of the line being filled.
- `ifd_cache_miss`  out  1  miss pulse.
- `ifd_near_miss`  out  1  qualifies a miss: the line is landing now, so the warp must retry rather than sleep.
- `ifd_cache_miss_warp_idx`  out  `NUM_WARP_PER_CORE_LOG`  warp that missed.
- `ifd_to_l2i_req_valid`  out  1  fill request valid.
- `ifd_to_l2i_req_ready`  in  1  L2 accepts the request.
- `ifd_to_l2i_req_addr`  out  `ADDR_WIDTH`  line-aligned address (low 6 bits are 0).
- `ifd_to_l2i_req_warp_idx`  out  `NUM_WARP_PER_CORE_LOG`  requesting warp.
- `dec_allowin`  in  1  decode can accept.
- `ifd_to_dec_valid`  out  1  decode bus valid.
- `ifd_to_dec_bus`  out  32+`ADDR_WIDTH`+`NUM_WARP_PER_CORE_LOG`  {inst, pc, warp_idx}.
- `wb_rollback_en`  in  1  rollback request from writeback.
- `wb_rollback_warp_idx`  in  `NUM_WARP_PER_CORE_LOG`  warp being rolled back.

## Operation
- **Acceptance.** `accept = ift_to_ifd_valid && ifd_allowin`.
- **Allow-in.** `ifd_allowin = (!out_valid_q || dec_allowin) && !miss_fifo_full`.
- **Hit detection.** `hit_way[i] = icache_tag_valid[i] && icache_tag[i] == pc[31:12]`.
- **Hit.** `inst` is selected from the hitting way at word `pc[5:2]`. On accept, the output register loads {inst, pc, warp_idx} and sets `out_valid_q`.
- **Multiple hitting ways.** Never expected; behaviour is undefined, and the bench treats it as an error.
- **Miss (no hit).** The output register is not loaded.
  - `ifd_cache_miss` pulses and `ifd_cache_miss_warp_idx` = warp_idx.
  - Near miss: if `l2i_fill_en && l2i_fill_set_idx == pc[11:6] && l2i_fill_tag == pc[31:12]`, `ifd_near_miss` also pulses and no L2 request is queued.
  - Otherwise the line-aligned address and warp are pushed into the miss FIFO.
- **Request merge.** If an entry with the same line address is already in the FIFO, no push happens. The tag stage is still told of the miss, and the L2 wakes every waiting warp by line.
- **Miss FIFO.** The head drives `ifd_to_l2i_req_*`, and the entry pops on `valid && ready`.
  - Simultaneous push and pop at full is legal; allow-in nevertheless already blocks acceptance while full.
- **Rollback.**
  - If `wb_rollback_en` matches the warp of an incoming transfer, the transfer is dropped: no output load, no miss pulse, no FIFO push.
  - If it matches `out_valid_q`'s warp, `out_valid_q` clears that cycle.
  - Already-queued L2 requests are kept.
- **Decode handshake.** Decode consumes the output on `out_valid_q && dec_allowin`. `out_valid_q` clears unless a new hit loads the register in the same cycle.

## Timing
- **Reset values.** All outputs are 0 after reset: `ifd_to_dec_valid`, `ifd_cache_miss`, `ifd_near_miss`, `ifd_to_l2i_req_valid`, buses and warp indices. `ifd_allowin` is 1 after reset.
- **Lookup timing.** Icache tag and data inputs are valid in the same cycle as `ift_to_ifd_valid`; the arrays are indexed one cycle earlier by the tag stage.
- **Hit latency.** A hit accepted in cycle N gives `ifd_to_dec_valid` = 1 in cycle N+1.
- **Miss pulses.** `ifd_cache_miss` and `ifd_near_miss` are registered and asserted for exactly cycle N+1.
- **L2 request latency.** A miss pushed in cycle N makes `ifd_to_l2i_req_valid` visible at N+1, provided the FIFO was empty.
- **Reset mid-operation.** Asynchronous reset empties the FIFO and the output register immediately.

## Configuration
- `IFD_PERF_COUNTER_EN`: compiles in 32-bit saturating `perf_hit_cnt` and `perf_miss_cnt` output ports.
  - They count accepted non-rolled-back hits and misses; near misses count as misses.
  - Both reset to 0.
- Without the macro, the ports and counters are absent.

## Structure
- The tag/set/offset widths, the `IFD_TO_DEC_BUS_WIDTH` and `IFT_TO_IFD_BUS_WIDTH` constants, and the line-address typedef belong in the shared defines package.
- The miss FIFO is a sub-module `ifd_miss_fifo` with push, pop, full, empty and an address-match lookup port.

## Test plan
- **Hit on way 2.** pc=0x44, warp 0, way-2 tag matches. Next cycle: valid=1, inst = way-2 word 1, pc=0x44, no miss pulse.
- **Cold miss.** pc=0x1000, all tag valids 0. Next cycle: miss=1, near=0, warp 0; req_valid=1 with addr=0x1000; with ready=1 the request pops.
- **Near miss.** Miss on pc=0x2040 while the fill for set 1, tag 0x2 is active. Result: miss=1, near=1, no L2 request.
- **Merge and backpressure.** Warps 1 and 2 both miss on line 0x3000 with ready=0: one FIFO entry only. Then misses on two further lines: FIFO full, allowin=0.
- **Decode stall.** dec_allowin=0 with output valid: allowin=0 and the output is held. Release: consumed, and the next hit is accepted in the same cycle.
- **Rollback.** Rollback of warp 3 during its incoming hit, and during its held output. Both are dropped: no valid and no miss pulse.

Source files
------------

// File: rtl/ifetch_data_stage_pkg.sv
// Shared defines for the instruction-fetch data stage: address split widths,
// inter-stage bus widths and the cache-line address type.
package ifetch_data_stage_pkg;

  localparam int unsigned IFD_ADDR_WIDTH        = 32;
  localparam int unsigned IFD_NUM_WARP_PER_CORE = 4;
  localparam int unsigned IFD_WARP_IDX_WIDTH    = $clog2(IFD_NUM_WARP_PER_CORE);
  localparam int unsigned IFD_L1_CACHE_NUM_WAYS = 4;
  localparam int unsigned IFD_L1_CACHE_NUM_SETS = 64;
  localparam int unsigned IFD_CACHE_LINE_BYTES  = 64;
  localparam int unsigned IFD_MISS_FIFO_DEPTH   = 2;

  localparam int unsigned IFD_OFFSET_WIDTH = $clog2(IFD_CACHE_LINE_BYTES);
  localparam int unsigned IFD_SET_WIDTH    = $clog2(IFD_L1_CACHE_NUM_SETS);
  localparam int unsigned IFD_TAG_WIDTH    = IFD_ADDR_WIDTH - IFD_SET_WIDTH - IFD_OFFSET_WIDTH;
  localparam int unsigned IFD_LINE_BITS    = IFD_CACHE_LINE_BYTES * 8;
  localparam int unsigned IFD_LINE_WIDTH   = IFD_ADDR_WIDTH - IFD_OFFSET_WIDTH;

  localparam int unsigned IFT_TO_IFD_BUS_WIDTH = IFD_ADDR_WIDTH + IFD_WARP_IDX_WIDTH;
  localparam int unsigned IFD_TO_DEC_BUS_WIDTH = 32 + IFD_ADDR_WIDTH + IFD_WARP_IDX_WIDTH;

  typedef logic [IFD_LINE_WIDTH-1:0] ifd_line_addr_t;

endpackage

// File: rtl/ifetch_data_stage_if.sv
// Line-fill request channel from the fetch data stage toward the L2 interface.
interface ifetch_data_stage_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned WARP_IDX_WIDTH = 2
);

  logic                      ifd_to_l2i_req_valid;
  logic                      ifd_to_l2i_req_ready;
  logic [ADDR_WIDTH-1:0]     ifd_to_l2i_req_addr;
  logic [WARP_IDX_WIDTH-1:0] ifd_to_l2i_req_warp_idx;

  modport master (
    output ifd_to_l2i_req_valid,
    output ifd_to_l2i_req_addr,
    output ifd_to_l2i_req_warp_idx,
    input  ifd_to_l2i_req_ready
  );

  modport slave (
    input  ifd_to_l2i_req_valid,
    input  ifd_to_l2i_req_addr,
    input  ifd_to_l2i_req_warp_idx,
    output ifd_to_l2i_req_ready
  );

endinterface

// File: rtl/ifetch_data_stage_miss_fifo.sv
// Pending L2 line-fill request FIFO with a line-address lookup used to merge
// repeated misses on the same line.
module ifd_miss_fifo #(
  parameter int unsigned LINE_W = 26,
  parameter int unsigned WARP_W = 2,
  parameter int unsigned DEPTH  = 2
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [LINE_W-1:0] i_push_line,
  input  logic [WARP_W-1:0] i_push_warp,
  input  logic              i_pop,
  input  logic [LINE_W-1:0] i_lookup_line,
  output logic              o_lookup_hit,
  output logic              o_full,
  output logic              o_empty,
  output logic [LINE_W-1:0] o_head_line,
  output logic [WARP_W-1:0] o_head_warp
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LINE_W-1:0] r_line [DEPTH];
  logic [WARP_W-1:0] r_warp [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_full    = &r_vld;
  assign o_empty   = ~|r_vld;
  assign w_do_pop  = i_pop && !o_empty;
  // A push while full is only taken when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_head_line = r_line[r_rd_ptr];
  assign o_head_warp = r_warp[r_rd_ptr];

  always_comb begin
    o_lookup_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_line[i] == i_lookup_line)) o_lookup_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_line[i] <= '0;
        r_warp[i] <= '0;
      end
    end else begin
      if (w_do_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_do_push) begin
        r_vld[r_wr_ptr]  <= 1'b1;
        r_line[r_wr_ptr] <= i_push_line;
        r_warp[r_wr_ptr] <= i_push_warp;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_data_stage.sv
// Fetch data stage: tag compare, instruction select, miss reporting and L2
// request queueing. Optional IFD_PERF_COUNTER_EN adds hit/miss counters.
module ifetch_data_stage
  import ifetch_data_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = IFD_ADDR_WIDTH,
  parameter int unsigned NUM_WARP_PER_CORE = IFD_NUM_WARP_PER_CORE,
  parameter int unsigned L1_CACHE_NUM_WAYS = IFD_L1_CACHE_NUM_WAYS,
  parameter int unsigned L1_CACHE_NUM_SETS = IFD_L1_CACHE_NUM_SETS,
  parameter int unsigned CACHE_LINE_BYTES  = IFD_CACHE_LINE_BYTES,
  parameter int unsigned MISS_FIFO_DEPTH   = IFD_MISS_FIFO_DEPTH,
  localparam int unsigned NUM_WARP_PER_CORE_LOG = $clog2(NUM_WARP_PER_CORE),
  localparam int unsigned L1_CACHE_NUM_SETS_LOG = $clog2(L1_CACHE_NUM_SETS),
  localparam int unsigned OFF_W     = $clog2(CACHE_LINE_BYTES),
  localparam int unsigned TAG_W     = ADDR_WIDTH - L1_CACHE_NUM_SETS_LOG - OFF_W,
  localparam int unsigned LINE_BITS = CACHE_LINE_BYTES * 8
)(
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        ift_to_ifd_valid,
  input  logic [ADDR_WIDTH+NUM_WARP_PER_CORE_LOG-1:0] ift_to_ifd_bus,
  output logic                                        ifd_allowin,
  input  logic [L1_CACHE_NUM_WAYS-1:0]                icache_tag_valid,
  input  logic [L1_CACHE_NUM_WAYS*TAG_W-1:0]          icache_tag,
  input  logic [L1_CACHE_NUM_WAYS*LINE_BITS-1:0]      icache_data,
  input  logic                                        l2i_fill_en,
  input  logic [L1_CACHE_NUM_SETS_LOG-1:0]            l2i_fill_set_idx,
  input  logic [TAG_W-1:0]                            l2i_fill_tag,
  output logic                                        ifd_cache_miss,
  output logic                                        ifd_near_miss,
  output logic [NUM_WARP_PER_CORE_LOG-1:0]            ifd_cache_miss_warp_idx,
  ifetch_data_stage_if.master                         l2i,
  input  logic                                        dec_allowin,
  output logic                                        ifd_to_dec_valid,
  output logic [32+ADDR_WIDTH+NUM_WARP_PER_CORE_LOG-1:0] ifd_to_dec_bus,
`ifdef IFD_PERF_COUNTER_EN
  output logic [31:0]                                 perf_hit_cnt,
  output logic [31:0]                                 perf_miss_cnt,
`endif
  input  logic                                        wb_rollback_en,
  input  logic [NUM_WARP_PER_CORE_LOG-1:0]            wb_rollback_warp_idx
);

  localparam int unsigned WL     = NUM_WARP_PER_CORE_LOG;
  localparam int unsigned WORD_W = $clog2(CACHE_LINE_BYTES / 4);
  localparam int unsigned LINE_W = ADDR_WIDTH - OFF_W;

  logic [ADDR_WIDTH-1:0]            w_pc;
  logic [WL-1:0]                    w_warp;
  logic [TAG_W-1:0]                 w_tag;
  logic [L1_CACHE_NUM_SETS_LOG-1:0] w_set;
  logic [WORD_W-1:0]                w_word;
  logic [LINE_W-1:0]                w_line;
  logic [L1_CACHE_NUM_WAYS-1:0]     w_hit_way;
  logic [31:0]                      w_inst;
  logic                             w_is_hit;
  logic                             w_near_hit;
  logic                             w_accept;
  logic                             w_rb_in;
  logic                             w_rb_out;
  logic                             w_take;
  logic                             w_load;
  logic                             w_miss;
  logic                             w_out_valid_nxt;
  logic                             w_fifo_push;
  logic                             w_fifo_pop;
  logic                             w_fifo_full;
  logic                             w_fifo_empty;
  logic                             w_fifo_match;
  logic [LINE_W-1:0]                w_head_line;
  logic [WL-1:0]                    w_head_warp;

  logic                                 r_out_valid;
  logic [32+ADDR_WIDTH+WL-1:0]          r_out_bus;
  logic                                 r_miss;
  logic                                 r_near;
  logic [WL-1:0]                        r_miss_warp;

  assign w_pc   = ift_to_ifd_bus[ADDR_WIDTH+WL-1:WL];
  assign w_warp = ift_to_ifd_bus[WL-1:0];
  assign w_tag  = w_pc[ADDR_WIDTH-1 -: TAG_W];
  assign w_set  = w_pc[OFF_W +: L1_CACHE_NUM_SETS_LOG];
  assign w_word = w_pc[2 +: WORD_W];
  assign w_line = w_pc[ADDR_WIDTH-1:OFF_W];

  // Ways are assumed one-hot on hit, so the select is a plain OR of masked words.
  always_comb begin
    w_hit_way = '0;
    w_inst    = '0;
    for (int unsigned i = 0; i < L1_CACHE_NUM_WAYS; i++) begin
      w_hit_way[i] = icache_tag_valid[i] && (icache_tag[i*TAG_W +: TAG_W] == w_tag);
      if (w_hit_way[i]) w_inst = w_inst | icache_data[i*LINE_BITS + 32*int'(w_word) +: 32];
    end
  end

  assign w_is_hit   = |w_hit_way;
  assign w_near_hit = l2i_fill_en && (l2i_fill_set_idx == w_set) && (l2i_fill_tag == w_tag);

  assign ifd_allowin = (!r_out_valid || dec_allowin) && !w_fifo_full;
  assign w_accept    = ift_to_ifd_valid && ifd_allowin;
  assign w_rb_in     = wb_rollback_en && (wb_rollback_warp_idx == w_warp);
  assign w_rb_out    = wb_rollback_en && (wb_rollback_warp_idx == r_out_bus[WL-1:0]);
  assign w_take      = w_accept && !w_rb_in;
  assign w_load      = w_take && w_is_hit;
  assign w_miss      = w_take && !w_is_hit;
  assign w_fifo_push = w_miss && !w_near_hit && !w_fifo_match;
  assign w_fifo_pop  = l2i.ifd_to_l2i_req_valid && l2i.ifd_to_l2i_req_ready;

  always_comb begin
    w_out_valid_nxt = r_out_valid;
    if (w_load) w_out_valid_nxt = 1'b1;
    else if (w_rb_out || dec_allowin) w_out_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_bus   <= '0;
      r_miss      <= 1'b0;
      r_near      <= 1'b0;
      r_miss_warp <= '0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      if (w_load) r_out_bus <= {w_inst, w_pc, w_warp};
      r_miss <= w_miss;
      r_near <= w_miss && w_near_hit;
      if (w_miss) r_miss_warp <= w_warp;
    end
  end

  ifd_miss_fifo #(
    .LINE_W (LINE_W),
    .WARP_W (WL),
    .DEPTH  (MISS_FIFO_DEPTH)
  ) u_miss_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (w_fifo_push),
    .i_push_line   (w_line),
    .i_push_warp   (w_warp),
    .i_pop         (w_fifo_pop),
    .i_lookup_line (w_line),
    .o_lookup_hit  (w_fifo_match),
    .o_full        (w_fifo_full),
    .o_empty       (w_fifo_empty),
    .o_head_line   (w_head_line),
    .o_head_warp   (w_head_warp)
  );

  assign ifd_to_dec_valid            = r_out_valid;
  assign ifd_to_dec_bus              = r_out_bus;
  assign ifd_cache_miss              = r_miss;
  assign ifd_near_miss               = r_near;
  assign ifd_cache_miss_warp_idx     = r_miss_warp;
  assign l2i.ifd_to_l2i_req_valid    = !w_fifo_empty;
  assign l2i.ifd_to_l2i_req_addr     = {w_head_line, {OFF_W{1'b0}}};
  assign l2i.ifd_to_l2i_req_warp_idx = w_head_warp;

`ifdef IFD_PERF_COUNTER_EN
  logic [31:0] r_perf_hit;
  logic [31:0] r_perf_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_hit  <= '0;
      r_perf_miss <= '0;
    end else begin
      if (w_load && !(&r_perf_hit))  r_perf_hit  <= r_perf_hit + 32'd1;
      if (w_miss && !(&r_perf_miss)) r_perf_miss <= r_perf_miss + 32'd1;
    end
  end

  assign perf_hit_cnt  = r_perf_hit;
  assign perf_miss_cnt = r_perf_miss;
`endif

endmodule

// File: tb/tb_ifetch_data_stage.sv
// Self-checking bench for ifetch_data_stage: directed scenarios plus random
// traffic compared each cycle against a queue-based behavioural model.
module tb_ifetch_data_stage;
  import ifetch_data_stage_pkg::*;

  localparam int unsigned AW = IFD_ADDR_WIDTH;
  localparam int unsigned WL = IFD_WARP_IDX_WIDTH;
  localparam int unsigned NW = IFD_L1_CACHE_NUM_WAYS;
  localparam int unsigned TW = IFD_TAG_WIDTH;
  localparam int unsigned LB = IFD_LINE_BITS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                            ift_to_ifd_valid;
  logic [IFT_TO_IFD_BUS_WIDTH-1:0] ift_to_ifd_bus;
  logic                            ifd_allowin;
  logic [NW-1:0]                   icache_tag_valid;
  logic [NW*TW-1:0]                icache_tag;
  logic [NW*LB-1:0]                icache_data;
  logic                            l2i_fill_en;
  logic [IFD_SET_WIDTH-1:0]        l2i_fill_set_idx;
  logic [TW-1:0]                   l2i_fill_tag;
  logic                            ifd_cache_miss;
  logic                            ifd_near_miss;
  logic [WL-1:0]                   ifd_cache_miss_warp_idx;
  logic                            dec_allowin;
  logic                            ifd_to_dec_valid;
  logic [IFD_TO_DEC_BUS_WIDTH-1:0] ifd_to_dec_bus;
  logic                            wb_rollback_en;
  logic [WL-1:0]                   wb_rollback_warp_idx;
`ifdef IFD_PERF_COUNTER_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  ifetch_data_stage_if #(.ADDR_WIDTH(AW), .WARP_IDX_WIDTH(WL)) l2i ();

  ifetch_data_stage dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ift_to_ifd_valid        (ift_to_ifd_valid),
    .ift_to_ifd_bus          (ift_to_ifd_bus),
    .ifd_allowin             (ifd_allowin),
    .icache_tag_valid        (icache_tag_valid),
    .icache_tag              (icache_tag),
    .icache_data             (icache_data),
    .l2i_fill_en             (l2i_fill_en),
    .l2i_fill_set_idx        (l2i_fill_set_idx),
    .l2i_fill_tag            (l2i_fill_tag),
    .ifd_cache_miss          (ifd_cache_miss),
    .ifd_near_miss           (ifd_near_miss),
    .ifd_cache_miss_warp_idx (ifd_cache_miss_warp_idx),
    .l2i                     (l2i),
    .dec_allowin             (dec_allowin),
    .ifd_to_dec_valid        (ifd_to_dec_valid),
    .ifd_to_dec_bus          (ifd_to_dec_bus),
`ifdef IFD_PERF_COUNTER_EN
    .perf_hit_cnt            (perf_hit_cnt),
    .perf_miss_cnt           (perf_miss_cnt),
`endif
    .wb_rollback_en          (wb_rollback_en),
    .wb_rollback_warp_idx    (wb_rollback_warp_idx)
  );

  int checks   = 0;
  int failures = 0;

  // Stimulus view of the looked-up set.
  logic [TW-1:0] s_tag [NW];
  logic [LB-1:0] s_dat [NW];
  logic [NW-1:0] s_vld;

  // Behavioural model state (what the registered outputs must show).
  bit                            m_out_valid;
  logic [IFD_TO_DEC_BUS_WIDTH-1:0] m_out_bus;
  bit                            m_miss;
  bit                            m_near;
  logic [WL-1:0]                 m_miss_warp;
  logic [AW-1:0]                 q_addr [$];
  logic [WL-1:0]                 q_warp [$];

  task automatic chk(input string nm, input logic [IFD_TO_DEC_BUS_WIDTH-1:0] act,
                     input logic [IFD_TO_DEC_BUS_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply_ways();
    for (int i = 0; i < NW; i++) begin
      icache_tag[i*TW +: TW]  = s_tag[i];
      icache_data[i*LB +: LB] = s_dat[i];
    end
    icache_tag_valid = s_vld;
  endtask

  task automatic drive_req(input bit v, input logic [AW-1:0] pc, input logic [WL-1:0] w);
    ift_to_ifd_valid = v;
    ift_to_ifd_bus   = {pc, w};
  endtask

  task automatic idle_inputs();
    drive_req(1'b0, '0, '0);
    for (int i = 0; i < NW; i++) begin
      s_tag[i] = '0;
      s_dat[i] = '0;
    end
    s_vld = '0;
    apply_ways();
    l2i_fill_en = 1'b0;
    l2i_fill_set_idx = '0;
    l2i_fill_tag = '0;
    l2i.ifd_to_l2i_req_ready = 1'b0;
    dec_allowin = 1'b1;
    wb_rollback_en = 1'b0;
    wb_rollback_warp_idx = '0;
  endtask

  task automatic model_reset();
    m_out_valid = 0;
    m_out_bus   = '0;
    m_miss      = 0;
    m_near      = 0;
    m_miss_warp = '0;
    q_addr.delete();
    q_warp.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_dec_valid", ifd_to_dec_valid, 0);
    chk("rst_dec_bus", ifd_to_dec_bus, 0);
    chk("rst_miss", ifd_cache_miss, 0);
    chk("rst_near", ifd_near_miss, 0);
    chk("rst_miss_warp", ifd_cache_miss_warp_idx, 0);
    chk("rst_req_valid", l2i.ifd_to_l2i_req_valid, 0);
    chk("rst_req_addr", l2i.ifd_to_l2i_req_addr, 0);
    chk("rst_req_warp", l2i.ifd_to_l2i_req_warp_idx, 0);
    chk("rst_allowin", ifd_allowin, 1);
  endtask

  // One clock: evaluate the stage rules on the inputs currently driven,
  // let the edge happen, then compare every registered output.
  task automatic tick();
    logic [AW-1:0] pc, line;
    logic [WL-1:0] wp;
    logic [31:0]   inst;
    int  hits, hw;
    bit  allow, acc, drop, near, merged, rb_out;
    #1;
    pc = ift_to_ifd_bus[AW+WL-1:WL];
    wp = ift_to_ifd_bus[WL-1:0];
    allow = (!m_out_valid || dec_allowin) && (q_addr.size() < IFD_MISS_FIFO_DEPTH);
    chk("allowin", ifd_allowin, allow);
    hits = 0;
    hw = 0;
    for (int i = 0; i < NW; i++)
      if (s_vld[i] && s_tag[i] == TW'(pc >> 12)) begin hits++; hw = i; end
    acc    = ift_to_ifd_valid && allow;
    drop   = wb_rollback_en && (wb_rollback_warp_idx == wp);
    line   = pc & ~32'h3f;
    near   = l2i_fill_en && (l2i_fill_set_idx == 6'((pc >> 6) & 32'h3f)) && (l2i_fill_tag == TW'(pc >> 12));
    merged = 0;
    foreach (q_addr[k]) if (q_addr[k] == line) merged = 1;
    rb_out = wb_rollback_en && (wb_rollback_warp_idx == m_out_bus[WL-1:0]);

    if (q_addr.size() > 0 && l2i.ifd_to_l2i_req_ready) begin
      void'(q_addr.pop_front());
      void'(q_warp.pop_front());
    end
    m_miss = acc && !drop && hits == 0;
    m_near = m_miss && near;
    if (m_miss) m_miss_warp = wp;
    if (m_miss && !near && !merged) begin
      q_addr.push_back(line);
      q_warp.push_back(wp);
    end
    if (acc && !drop && hits == 1) begin
      inst = 32'(s_dat[hw] >> (32 * ((pc >> 2) & 32'hf)));
      m_out_bus   = {inst, pc, wp};
      m_out_valid = 1;
    end else if (m_out_valid && (dec_allowin || rb_out)) begin
      m_out_valid = 0;
    end

    @(posedge clk);
    @(negedge clk);
    chk("dec_valid", ifd_to_dec_valid, m_out_valid);
    if (m_out_valid) chk("dec_bus", ifd_to_dec_bus, m_out_bus);
    chk("miss", ifd_cache_miss, m_miss);
    chk("near", ifd_near_miss, m_near);
    if (m_miss) chk("miss_warp", ifd_cache_miss_warp_idx, m_miss_warp);
    chk("req_valid", l2i.ifd_to_l2i_req_valid, q_addr.size() > 0);
    if (q_addr.size() > 0) begin
      chk("req_addr", l2i.ifd_to_l2i_req_addr, q_addr[0]);
      chk("req_warp", l2i.ifd_to_l2i_req_warp_idx, q_warp[0]);
    end
  endtask

  task automatic randomize_cycle();
    logic [AW-1:0] pc;
    bit found;
    pc = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
    drive_req($urandom_range(0, 3) != 0, pc, WL'($urandom_range(0, 3)));
    found = 0;
    for (int i = 0; i < NW; i++) begin
      s_tag[i] = TW'($urandom_range(0, 3));
      s_vld[i] = $urandom_range(0, 1) == 1;
      for (int j = 0; j < LB / 32; j++) s_dat[i][j*32 +: 32] = $urandom;
      if (s_vld[i] && s_tag[i] == TW'(pc >> 12)) begin
        if (found) s_vld[i] = 1'b0;
        found = 1;
      end
    end
    apply_ways();
    l2i_fill_en = $urandom_range(0, 3) == 0;
    l2i_fill_set_idx = 6'($urandom_range(0, 3));
    l2i_fill_tag = TW'($urandom_range(0, 3));
    l2i.ifd_to_l2i_req_ready = $urandom_range(0, 1) == 1;
    dec_allowin = $urandom_range(0, 3) != 0;
    wb_rollback_en = $urandom_range(0, 7) == 0;
    wb_rollback_warp_idx = WL'($urandom_range(0, 3));
  endtask

  task automatic setup_way2();
    s_vld = 4'b0100;
    s_tag[2] = '0;
    s_dat[2][1*32 +: 32] = 32'hDEADBEEF;
    s_dat[2][2*32 +: 32] = 32'hCAFEF00D;
    apply_ways();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Hit on way 2
    setup_way2();
    drive_req(1'b1, 32'h44, 2'd0);
    tick();
    chk("hit_valid", ifd_to_dec_valid, 1);
    chk("hit_bus", ifd_to_dec_bus, {32'hDEADBEEF, 32'h44, 2'd0});
    chk("hit_no_miss", ifd_cache_miss, 0);
    drive_req(1'b0, '0, '0);
    tick();

    // Cold miss
    s_vld = '0;
    apply_ways();
    drive_req(1'b1, 32'h1000, 2'd0);
    tick();
    chk("cold_miss", ifd_cache_miss, 1);
    chk("cold_near", ifd_near_miss, 0);
    chk("cold_req_valid", l2i.ifd_to_l2i_req_valid, 1);
    chk("cold_req_addr", l2i.ifd_to_l2i_req_addr, 32'h1000);
    drive_req(1'b0, '0, '0);
    l2i.ifd_to_l2i_req_ready = 1'b1;
    tick();
    chk("cold_popped", l2i.ifd_to_l2i_req_valid, 0);
    l2i.ifd_to_l2i_req_ready = 1'b0;

    // Near miss
    l2i_fill_en = 1'b1;
    l2i_fill_set_idx = 6'd1;
    l2i_fill_tag = 20'h2;
    drive_req(1'b1, 32'h2040, 2'd1);
    tick();
    chk("near_miss", ifd_cache_miss, 1);
    chk("near_near", ifd_near_miss, 1);
    chk("near_no_req", l2i.ifd_to_l2i_req_valid, 0);
    l2i_fill_en = 1'b0;

    // Merge and backpressure
    drive_req(1'b1, 32'h3000, 2'd1);
    tick();
    drive_req(1'b1, 32'h3004, 2'd2);
    tick();
    chk("merge_miss_warp", ifd_cache_miss_warp_idx, 2'd2);
    chk("merge_head_addr", l2i.ifd_to_l2i_req_addr, 32'h3000);
    chk("merge_head_warp", l2i.ifd_to_l2i_req_warp_idx, 2'd1);
    drive_req(1'b1, 32'h4000, 2'd0);
    tick();
    drive_req(1'b1, 32'h5000, 2'd3);
    #1 chk("full_allowin", ifd_allowin, 0);
    tick();
    chk("full_no_accept", ifd_cache_miss, 0);
    drive_req(1'b0, '0, '0);
    l2i.ifd_to_l2i_req_ready = 1'b1;
    tick();
    chk("pop_head_addr", l2i.ifd_to_l2i_req_addr, 32'h4000);
    tick();
    l2i.ifd_to_l2i_req_ready = 1'b0;

    // Decode stall
    setup_way2();
    dec_allowin = 1'b0;
    drive_req(1'b1, 32'h44, 2'd1);
    tick();
    drive_req(1'b1, 32'h48, 2'd2);
    #1 chk("stall_allowin", ifd_allowin, 0);
    tick();
    chk("stall_hold", ifd_to_dec_bus, {32'hDEADBEEF, 32'h44, 2'd1});
    dec_allowin = 1'b1;
    tick();
    chk("release_bus", ifd_to_dec_bus, {32'hCAFEF00D, 32'h48, 2'd2});
    drive_req(1'b0, '0, '0);
    tick();

    // Rollback: incoming transfer, then held output
    wb_rollback_en = 1'b1;
    wb_rollback_warp_idx = 2'd3;
    drive_req(1'b1, 32'h44, 2'd3);
    tick();
    chk("rb_in_valid", ifd_to_dec_valid, 0);
    chk("rb_in_miss", ifd_cache_miss, 0);
    wb_rollback_en = 1'b0;
    dec_allowin = 1'b0;
    tick();
    drive_req(1'b0, '0, '0);
    wb_rollback_en = 1'b1;
    tick();
    chk("rb_out_valid", ifd_to_dec_valid, 0);
    wb_rollback_en = 1'b0;
    dec_allowin = 1'b1;

    repeat (3000) begin
      randomize_cycle();
      tick();
    end

    // Asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
